operand_bram_writer: RTL
========================

# operand_bram_writer

Loads operand vectors into the two 16-entry operand BRAMs (A and B) that the multiplier datapath reads. It accepts a valid/ready stream of 32-bit words, writes the first DEPTH words to BRAM A and the next DEPTH words to BRAM B, then releases the downstream read/multiply chain. It sits upstream of the operand read path and drives each BRAM's write-side port (wea/addra/dina). While a load is in progress it holds the reader in reset, so no partially written vector is ever consumed.

## Interface
- DATA_W, 32, operand word width; matches BRAM data width.
- ADDR_W, 4, BRAM address width.
- DEPTH, 16, words per BRAM; must equal 2**ADDR_W.

- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begins a load; sampled only in IDLE.
- in_data  in  DATA_W  operand word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a word this cycle.
- wea_a  out  1  BRAM A write enable.
- addra_a  out  ADDR_W  BRAM A address.
- dina_a  out  DATA_W  BRAM A write data.
- wea_b  out  1  BRAM B write enable.
- addra_b  out  ADDR_W  BRAM B address.
- dina_b  out  DATA_W  BRAM B write data.
- busy  out  1  high in LOAD_A, LOAD_B and DONE.
- load_done  out  1  one-cycle pulse when both BRAMs are fully written.
- reader_reset  out  1  active-high reset for the downstream read chain.

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, DONE.
- IDLE:
  - If start=1, go to LOAD_A, clear the word counter, and drive reader_reset=1.
  - Otherwise stay in IDLE.
- LOAD_A / LOAD_B:
  - in_ready=1. A handshake is in_valid & in_ready.
  - Each handshake writes in_data to the current BRAM at the counter address, then increments the counter.
  - On the handshake at counter=DEPTH-1 in LOAD_A: the counter wraps to 0 and the FSM goes to LOAD_B.
  - On the handshake at counter=DEPTH-1 in LOAD_B: the FSM goes to DONE.
- DONE: lasts exactly one cycle, then goes to IDLE. On that transition load_done pulses and reader_reset drops to 0.
- in_ready=0 in IDLE and DONE. in_valid in these states is ignored and no write occurs.
- start is ignored outside IDLE, including in DONE.
- BRAM port outputs are registered:
  - wea_x is high for exactly one cycle per handshake.
  - addra_x and dina_x hold their last values when wea_x=0.
- wea_a and wea_b are never high in the same cycle.
- Exactly DEPTH writes go to each BRAM per load, in ascending address order 0..DEPTH-1.
- A write is never split across the A/B boundary.
- Reset values:
  - State is IDLE and the counter is 0.
  - in_ready, wea_a, wea_b, busy and load_done are 0.
  - addra_a, addra_b, dina_a and dina_b are 0.
  - reader_reset is 1.
- reader_reset stays 1 from reset until the first completed load.
- Reset mid-load: return to the reset state on the next edge.
  - The in-flight registered write, if any, is dropped.
  - No load_done is issued.
  - BRAM contents are left partial; the next start rewrites from A address 0.

## Timing
- Handshake at edge E: wea_x, addra_x and dina_x are valid in the cycle after E. The BRAM commits at edge E+1.
- start sampled at edge S: in_ready is 1 from the cycle after S.
- Final B handshake at edge E:
  - The cycle after E: state DONE and wea_b=1.
  - The cycle after E+1: state IDLE, load_done=1, reader_reset=0. The reader therefore never reads before the last write commits.
- Minimum load with in_valid held high: 2*DEPTH+2 cycles from the start edge to the load_done cycle.
- in_ready depends only on state (registered). There is no combinational path from in_valid to in_ready.
- Back-to-back loads: start=1 in the load_done cycle is accepted, because the FSM is already in IDLE. In the next cycle reader_reset=1 and the FSM is in LOAD_A.

## Test plan
- **Reset values.** Assert reset for 3 cycles, then release. Required: reader_reset=1, every other output 0, in_ready=0 until start.
- **Continuous load.** Pulse start, then hold in_valid=1 with data 0x00000001..0x00000020.
  - BRAM A address k holds k+1 and BRAM B address k holds 0x11+k.
  - load_done is a single pulse 34 cycles after the start edge (start cycle counted as 0), and reader_reset falls in that same cycle.
- **Gapped valid.** Drive the same data with in_valid toggling 1,0,0,1,… Required: identical BRAM contents, one wea per handshake, addresses contiguous with no skips or repeats, load_done only after the 32nd handshake.
- **Ignored inputs.** Drive in_valid=1 in IDLE, and pulse start during LOAD_B at word 20. Required: no wea in IDLE, counter and state unaffected, one load_done total.
- **Reset mid-load.** Assert reset after the 20th handshake.
  - Required: no load_done and reader_reset stays 1.
  - A new start followed by 32 words 0xA0.. writes A address 0 = 0xA0 and completes normally.
- **Back-to-back loads.** Assert start in the load_done cycle. Required: a second full load runs, with reader_reset high again on the next cycle, a second load_done exactly 34 cycles later, and contents overwritten with the new data.

Source files
------------

// File: rtl/operand_bram_writer.sv
`default_nettype none
// ============================================================================
// Module   : operand_bram_writer
// Brief    : Streams 2*DEPTH operand words into BRAM A then BRAM B and holds
//            the downstream reader in reset until both vectors are committed.
// Revision : 1.0
// ============================================================================
module operand_bram_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wea_a,
    output logic [ADDR_W-1:0] addra_a,
    output logic [DATA_W-1:0] dina_a,
    output logic              wea_b,
    output logic [ADDR_W-1:0] addra_b,
    output logic [DATA_W-1:0] dina_b,
    output logic              busy,
    output logic              load_done,
    output logic              reader_reset
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_load_a = 2'd1;
    localparam logic [1:0] c_st_load_b = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [ADDR_W-1:0] r_count;
    logic              w_in_ready;
    logic              w_busy;
    logic              w_hs;
    logic              w_last;
    logic              r_wea_a;
    logic              r_wea_b;
    logic [ADDR_W-1:0] r_addra_a;
    logic [ADDR_W-1:0] r_addra_b;
    logic [DATA_W-1:0] r_dina_a;
    logic [DATA_W-1:0] r_dina_b;
    logic              r_load_done;
    logic              r_reader_reset;

    assign w_hs   = in_valid & w_in_ready;
    assign w_last = (r_count == c_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:   if (start)          w_next = c_st_load_a;
            c_st_load_a: if (w_hs && w_last) w_next = c_st_load_b;
            c_st_load_b: if (w_hs && w_last) w_next = c_st_done;
            c_st_done:                       w_next = c_st_idle;
            default:                         w_next = c_st_idle;
        endcase
    end

    // in_ready is a pure decode of the state register, so in_valid never loops back into it
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            c_st_load_a, c_st_load_b: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            c_st_done: w_busy = 1'b1;
            default: begin
                w_in_ready = 1'b0;
                w_busy     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count        <= '0;
            r_wea_a        <= 1'b0;
            r_wea_b        <= 1'b0;
            r_addra_a      <= '0;
            r_addra_b      <= '0;
            r_dina_a       <= '0;
            r_dina_b       <= '0;
            r_load_done    <= 1'b0;
            r_reader_reset <= 1'b1;
        end else begin
            r_wea_a     <= w_hs && (r_state == c_st_load_a);
            r_wea_b     <= w_hs && (r_state == c_st_load_b);
            r_load_done <= (r_state == c_st_done);

            if ((r_state == c_st_idle) && start) begin
                r_count <= '0;
            end else if (w_hs) begin
                r_count <= r_count + c_one;
            end

            // Release the reader only once the final B write has committed
            if ((r_state == c_st_idle) && start) begin
                r_reader_reset <= 1'b1;
            end else if (r_state == c_st_done) begin
                r_reader_reset <= 1'b0;
            end

            if (w_hs && (r_state == c_st_load_a)) begin
                r_addra_a <= r_count;
                r_dina_a  <= in_data;
            end
            if (w_hs && (r_state == c_st_load_b)) begin
                r_addra_b <= r_count;
                r_dina_b  <= in_data;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign busy         = w_busy;
    assign wea_a        = r_wea_a;
    assign wea_b        = r_wea_b;
    assign addra_a      = r_addra_a;
    assign addra_b      = r_addra_b;
    assign dina_a       = r_dina_a;
    assign dina_b       = r_dina_b;
    assign load_done    = r_load_done;
    assign reader_reset = r_reader_reset;

endmodule
`default_nettype wire
